// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction fetch, data memory and ALU control bundle
interface alu_sequencer_if #(parameter int AW = 15);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [17:0]   imem_data;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [17:0]   dmem_wdata;
    logic          dmem_ack;
    logic [17:0]   dmem_rdata;
    logic          alu_en;
    logic [2:0]    alu_sig;
    logic [17:0]   alu_ina;
    logic [17:0]   alu_inb;
    logic [17:0]   alu_out;
    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               alu_en, alu_sig, alu_ina, alu_inb,
        input  imem_ack, imem_data, dmem_ack, dmem_rdata, alu_out
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               alu_en, alu_sig, alu_ina, alu_inb,
        output imem_ack, imem_data, dmem_ack, dmem_rdata, alu_out
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/mem/exec control with accumulator, pc and return stack
module alu_sequencer #(
    parameter int AW    = 15,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    alu_sequencer_if.master      bus,
    output logic [17:0]          acc,
    output logic [AW-1:0]        pc,
    output logic                 halted,
    output logic                 err
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, EXEC, HALT} state_t;
    localparam int PW = $clog2(DEPTH) + 1;
    state_t        state;
    logic [17:0]   ir, opnd, wdata;
    logic [AW-1:0] stk [DEPTH];
    logic [PW-1:0] sp;
    logic [PW-2:0] top;
    logic [2:0]    op;
    logic [AW-1:0] tgt, tos;
    logic          full, empty, exec, we;
    assign op    = ir[17:15];
    assign tgt   = ir[AW-1:0];
    assign full  = sp == PW'(DEPTH);
    assign empty = sp == '0;
    assign top   = sp[PW-2:0] - 1'b1;
    assign tos   = empty ? '0 : stk[top];
    assign exec  = state == EXEC;
    assign we    = state == MEM && op == 3'd2;
    assign halted = state == HALT;
    assign bus.imem_req   = state == FETCH;
    assign bus.imem_addr  = state == FETCH ? pc : '0;
    assign bus.dmem_req   = state == MEM;
    assign bus.dmem_we    = we;
    assign bus.dmem_addr  = state == MEM ? tgt : '0;
    assign bus.dmem_wdata = we ? wdata : '0;
    assign bus.alu_en     = exec;
    assign bus.alu_sig    = exec ? op : '0;
    // ALU operand routing: only EXEC presents non-zero values
    assign bus.alu_ina = !exec ? '0 : (op == 3'd0 || op == 3'd2) ? acc : op == 3'd1 ? opnd : '0;
    assign bus.alu_inb = !exec ? '0 : op == 3'd0 ? opnd : op == 3'd3 ? 18'(tgt) : op == 3'd4 ? 18'(tos) : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            acc   <= '0;
            sp    <= '0;
            err   <= 1'b0;
            ir    <= '0;
            opnd  <= '0;
            wdata <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= FETCH;
                FETCH: if (bus.imem_ack) begin
                    ir    <= bus.imem_data;
                    state <= DECODE;
                end
                DECODE: if (op > 3'd4) begin
                    err   <= 1'b1;
                    state <= HALT;
                end else state <= op < 3'd2 ? MEM : EXEC;
                MEM: if (bus.dmem_ack) begin
                    if (we) begin
                        pc    <= pc + 1'b1;
                        state <= FETCH;
                    end else begin
                        opnd  <= bus.dmem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    state <= FETCH;
                    case (op)
                        3'd0, 3'd1: begin
                            acc <= bus.alu_out;
                            pc  <= pc + 1'b1;
                        end
                        3'd2: begin
                            wdata <= bus.alu_out;
                            state <= MEM;
                        end
                        3'd3: if (full) begin
                            err   <= 1'b1;
                            state <= HALT;
                        end else begin
                            stk[sp[PW-2:0]] <= pc + 1'b1;
                            sp <= sp + 1'b1;
                            pc <= bus.alu_out[AW-1:0];
                        end
                        default: if (empty) begin
                            err   <= 1'b1;
                            state <= HALT;
                        end else begin
                            sp <= sp - 1'b1;
                            pc <= bus.alu_out[AW-1:0];
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against hand-computed results
module tb_alu_sequencer;
    logic clk, rst, start;
    logic [17:0] acc;
    logic [14:0] pc;
    logic halted, err;
    int checks = 0, errors = 0, cyc = 0;
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    int viol = 0, wecyc = 0;
    logic force_iack = 0;
    logic [31:0] sigcode = 0;
    logic [17:0] imem [0:32767];
    logic [17:0] dmem [0:32767];
    logic pdreq = 0;
    logic [33:0] pdbus = 0;
    int c0, c1, c2;

    alu_sequencer_if #(.AW(15)) bus();
    alu_sequencer #(.AW(15), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .acc(acc), .pc(pc), .halted(halted), .err(err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference ALU: add, pass ina for load/store, pass inb for call/ret
    always_comb
        bus.alu_out = bus.alu_sig == 3'd0 ? bus.alu_ina + bus.alu_inb :
                      (bus.alu_sig == 3'd1 || bus.alu_sig == 3'd2) ? bus.alu_ina : bus.alu_inb;

    // Memory responders: ack after iwait/dwait req cycles
    initial begin
        bus.imem_ack = 0; bus.imem_data = 0; bus.dmem_ack = 0; bus.dmem_rdata = 0;
        forever begin
            @(negedge clk);
            if (bus.imem_req && icnt >= iwait) begin
                bus.imem_ack = 1; bus.imem_data = imem[bus.imem_addr]; icnt = 0;
            end else begin
                bus.imem_ack = force_iack;
                icnt = bus.imem_req ? icnt + 1 : 0;
            end
            if (bus.dmem_req && dcnt >= dwait) begin
                bus.dmem_ack = 1; dcnt = 0;
                if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
                else bus.dmem_rdata = dmem[bus.dmem_addr];
            end else begin
                bus.dmem_ack = 0;
                dcnt = bus.dmem_req ? dcnt + 1 : 0;
            end
        end
    end

    // Bus monitor: ALU idle values, we/req pairing, stability while waiting
    initial forever begin
        @(negedge clk);
        if (bus.alu_en) sigcode = (sigcode << 4) | 32'(bus.alu_sig);
        else if (bus.alu_sig !== 0 || bus.alu_ina !== 0 || bus.alu_inb !== 0) viol++;
        if (bus.dmem_we && !bus.dmem_req) viol++;
        if (bus.dmem_req && bus.dmem_we) wecyc++;
        if (bus.dmem_req && pdreq && {bus.dmem_addr, bus.dmem_we, bus.dmem_wdata} !== pdbus) viol++;
        pdreq = bus.dmem_req;
        pdbus = {bus.dmem_addr, bus.dmem_we, bus.dmem_wdata};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fetch(input logic [14:0] a, output int c);
        int n = 0;
        while (!(bus.imem_req && bus.imem_addr == a) && n < 400) begin @(negedge clk); n++; end
        c = cyc;
        chk("fetch wait bound", 32'(n < 400), 1);
    endtask

    task automatic wait_pc(input logic [14:0] v, output int c);
        int n = 0;
        while (pc !== v && n < 400) begin @(negedge clk); n++; end
        c = cyc;
        chk("pc wait bound", 32'(n < 400), 1);
    endtask

    task automatic wait_halt(output int c);
        int n = 0;
        while (halted !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        c = cyc;
        chk("halt wait bound", 32'(n < 400), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; start = 0; iwait = 0; dwait = 0; force_iack = 0;
        for (int i = 0; i < 32768; i++) begin
            imem[i] = {3'd6, 15'd0};
            dmem[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        sigcode = 0;
        wecyc = 0;
    endtask

    task automatic go();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        rst = 1; start = 0;
        do_reset();
        chk("reset imem_req", 32'(bus.imem_req), 0);
        chk("reset dmem_req", 32'(bus.dmem_req), 0);
        chk("reset alu_en", 32'(bus.alu_en), 0);
        chk("reset acc", 32'(acc), 0);
        chk("reset pc", 32'(pc), 0);
        chk("reset halted", 32'(halted), 0);
        chk("reset err", 32'(err), 0);

        // ADD with carry dropped, then illegal opcode
        imem[0] = {3'd1, 15'd4};
        imem[1] = {3'd0, 15'd5};
        dmem[4] = 18'h00002;
        dmem[5] = 18'h3FFFF;
        go();
        wait_fetch(15'd1, c0);
        wait_pc(15'd2, c1);
        chk("add cycles", 32'(c1 - c0), 4);
        chk("add acc", 32'(acc), 32'h1);
        chk("add sigs", sigcode, 32'h10);
        wait_halt(c2);
        chk("illegal halt latency", 32'(c2 - c1), 2);
        chk("illegal err", 32'(err), 1);
        chk("illegal pc", 32'(pc), 2);
        go();
        repeat (3) @(negedge clk);
        chk("sticky halted", 32'(halted), 1);
        chk("sticky no fetch", 32'(bus.imem_req), 0);
        chk("sticky err", 32'(err), 1);

        // LOAD then STORE with a 3-cycle dmem wait
        do_reset();
        imem[0] = {3'd1, 15'd7};
        imem[1] = {3'd2, 15'd9};
        dmem[7] = 18'h12345;
        dwait = 3;
        go();
        wait_fetch(15'd1, c0);
        wait_pc(15'd2, c1);
        chk("store cycles", 32'(c1 - c0), 7);
        chk("store mem", 32'(dmem[9]), 32'h12345);
        chk("store acc", 32'(acc), 32'h12345);
        chk("store sigs", sigcode, 32'h12);
        chk("store we cycles", 32'(wecyc), 4);
        chk("store stable", 32'(viol), 0);
        wait_halt(c2);

        // CALL/RET nesting
        do_reset();
        imem[0]   = {3'd3, 15'd10};
        imem[10]  = {3'd3, 15'd100};
        imem[100] = {3'd4, 15'd0};
        imem[11]  = {3'd4, 15'd0};
        go();
        wait_fetch(15'd10, c0);
        wait_pc(15'd100, c1);
        chk("call cycles", 32'(c1 - c0), 3);
        wait_pc(15'd11, c2);
        chk("ret cycles", 32'(c2 - c1), 3);
        chk("ret pc", 32'(pc), 11);
        wait_pc(15'd1, c2);
        wait_halt(c2);
        chk("call/ret sigs", sigcode, 32'h3344);
        chk("call/ret err", 32'(err), 1);

        // Stack overflow on the ninth nested CALL
        do_reset();
        for (int i = 0; i < 9; i++) imem[i] = {3'd3, 15'(i + 1)};
        go();
        wait_fetch(15'd8, c0);
        wait_halt(c1);
        chk("overflow halt latency", 32'(c1 - c0), 3);
        chk("overflow pc", 32'(pc), 8);
        chk("overflow err", 32'(err), 1);

        // RET with empty stack
        do_reset();
        imem[0] = {3'd4, 15'd0};
        go();
        wait_halt(c0);
        chk("underflow err", 32'(err), 1);
        chk("underflow pc", 32'(pc), 0);

        // pc wrap from 7FFF to 0
        do_reset();
        imem[0]      = {3'd3, 15'h7FFF};
        imem[15'h7FFF] = {3'd1, 15'd4};
        dmem[4] = 18'h0002A;
        go();
        wait_pc(15'h7FFF, c0);
        wait_pc(15'd0, c1);
        chk("wrap cycles", 32'(c1 - c0), 4);
        chk("wrap acc", 32'(acc), 32'h2A);
        wait_halt(c2);
        chk("wrap overflow pc", 32'(pc), 0);

        // Reset during a pending fetch; ack lands on the reset edge, then a stray ack
        do_reset();
        imem[0] = {3'd1, 15'd4};
        dmem[4] = 18'h00005;
        iwait = 2;
        go();
        @(negedge clk);
        chk("pending fetch", 32'(bus.imem_req), 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst imem_req", 32'(bus.imem_req), 0);
        chk("rst imem_addr", 32'(bus.imem_addr), 0);
        chk("rst dmem_req", 32'(bus.dmem_req), 0);
        chk("rst alu_en", 32'(bus.alu_en), 0);
        chk("rst halted", 32'(halted), 0);
        force_iack = 1;
        repeat (3) @(negedge clk);
        force_iack = 0;
        chk("late ack ignored req", 32'(bus.imem_req), 0);
        chk("late ack ignored dmem", 32'(bus.dmem_req), 0);
        chk("late ack ignored pc", 32'(pc), 0);
        iwait = 0;
        go();
        wait_pc(15'd1, c0);
        chk("resume acc", 32'(acc), 5);
        chk("bus rule violations", 32'(viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
